// File: rtl/hub75_bcm_scan.sv
// HUB75 LED panel scan driver: per scan line and bit-plane, shift one row of pixels,
// blank, latch, then light for BASE_ONTIME<<plane cycles (binary-coded modulation).
module hub75_bcm_scan #(
    parameter int COLS        = 64,
    parameter int COLBITS     = 6,
    parameter int SCAN_ROWS   = 32,
    parameter int ROWBITS     = 5,
    parameter int BITDEPTH    = 8,
    parameter int BASE_ONTIME = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    rd_en,
    output logic [COLBITS-1:0]      rd_col,
    output logic [ROWBITS-1:0]      rd_row,
    input  logic [3*BITDEPTH-1:0]   rd_data1,
    input  logic [3*BITDEPTH-1:0]   rd_data2,
    output logic [ROWBITS-1:0]      led_addr,
    output logic                    led_blank,
    output logic                    led_latch,
    output logic                    led_sclk,
    output logic [2:0]              led_rgb1,
    output logic [2:0]              led_rgb2,
    output logic                    frame_done,
    output logic [2:0]              dbg_state
);

    localparam int SHIFT_LEN = 2 * COLS + 2;
    localparam int SCW       = $clog2(SHIFT_LEN);
    localparam int MAX_ON    = BASE_ONTIME << (BITDEPTH - 1);
    localparam int ONW       = $clog2(MAX_ON + 1);
    localparam int PLW       = (BITDEPTH > 1) ? $clog2(BITDEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        BLANK = 3'd2,
        LATCH = 3'd3,
        SHOW  = 3'd4
    } state_t;

    state_t               state_q;
    logic [SCW-1:0]       shift_cnt_q;
    logic [ONW-1:0]       on_cnt_q;
    logic [PLW-1:0]       plane_q;
    logic [ROWBITS-1:0]   row_q;

    logic                 rd_en_q;
    logic [COLBITS-1:0]   rd_col_q;
    logic [ROWBITS-1:0]   rd_row_q;
    logic [ROWBITS-1:0]   led_addr_q;
    logic                 led_blank_q;
    logic                 led_latch_q;
    logic                 led_sclk_q;
    logic [2:0]           led_rgb1_q;
    logic [2:0]           led_rgb2_q;
    logic                 frame_done_q;

    logic                 last_plane_d;
    logic                 last_row_d;
    logic [PLW-1:0]       next_plane_d;
    logic [ROWBITS-1:0]   next_row_d;
    logic [SCW:0]         cnt_next_d;
    logic [ONW-1:0]       on_len_d;

    // Selects bit 'p' of each of the R, G and B channels packed as {R,G,B}.
    function automatic logic [2:0] plane_bits(input logic [3*BITDEPTH-1:0] px,
                                              input logic [PLW-1:0] p);
        logic [BITDEPTH-1:0] r, g, b;
        r = px[3*BITDEPTH-1:2*BITDEPTH];
        g = px[2*BITDEPTH-1:BITDEPTH];
        b = px[BITDEPTH-1:0];
        return {r[p], g[p], b[p]};
    endfunction

    always_comb begin
        last_plane_d = (plane_q == PLW'(BITDEPTH - 1));
        last_row_d   = (row_q == ROWBITS'(SCAN_ROWS - 1));
        next_plane_d = last_plane_d ? '0 : plane_q + PLW'(1);
        next_row_d   = row_q;
        if (last_plane_d) begin
            next_row_d = last_row_d ? '0 : row_q + ROWBITS'(1);
        end
        cnt_next_d = {1'b0, shift_cnt_q} + (SCW+1)'(1);
        on_len_d   = ONW'(BASE_ONTIME) << plane_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_cnt_q  <= '0;
            on_cnt_q     <= '0;
            plane_q      <= '0;
            row_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_col_q     <= '0;
            rd_row_q     <= '0;
            led_addr_q   <= '0;
            led_blank_q  <= 1'b1;
            led_latch_q  <= 1'b0;
            led_sclk_q   <= 1'b0;
            led_rgb1_q   <= '0;
            led_rgb2_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rd_en_q     <= 1'b0;
                    led_sclk_q  <= 1'b0;
                    led_latch_q <= 1'b0;
                    led_blank_q <= 1'b1;
                    if (enable) begin
                        state_q     <= SHIFT;
                        shift_cnt_q <= '0;
                        rd_en_q     <= 1'b1;
                        rd_col_q    <= '0;
                        rd_row_q    <= row_q;
                    end
                end
                SHIFT: begin
                    // Read data for column c lands one cycle after its strobe (odd count).
                    if (shift_cnt_q[0] && shift_cnt_q < SCW'(2 * COLS)) begin
                        led_rgb1_q <= plane_bits(rd_data1, plane_q);
                        led_rgb2_q <= plane_bits(rd_data2, plane_q);
                    end
                    if (shift_cnt_q == SCW'(SHIFT_LEN - 1)) begin
                        state_q    <= BLANK;
                        rd_en_q    <= 1'b0;
                        led_sclk_q <= 1'b0;
                    end else begin
                        shift_cnt_q <= cnt_next_d[SCW-1:0];
                        rd_en_q     <= ~cnt_next_d[0] && (cnt_next_d < (SCW+1)'(2 * COLS));
                        rd_col_q    <= COLBITS'(cnt_next_d >> 1);
                        led_sclk_q  <= cnt_next_d[0] && (cnt_next_d >= (SCW+1)'(3));
                    end
                end
                BLANK: begin
                    state_q     <= LATCH;
                    led_latch_q <= 1'b1;
                    led_sclk_q  <= 1'b0;
                    led_addr_q  <= row_q;
                end
                LATCH: begin
                    state_q      <= SHOW;
                    led_latch_q  <= 1'b0;
                    led_blank_q  <= 1'b0;
                    on_cnt_q     <= on_len_d - ONW'(1);
                    frame_done_q <= (on_len_d == ONW'(1)) && last_plane_d && last_row_d;
                end
                SHOW: begin
                    if (on_cnt_q == '0) begin
                        led_blank_q <= 1'b1;
                        plane_q     <= next_plane_d;
                        row_q       <= next_row_d;
                        if (!(last_plane_d && last_row_d) || enable) begin
                            state_q     <= SHIFT;
                            shift_cnt_q <= '0;
                            rd_en_q     <= 1'b1;
                            rd_col_q    <= '0;
                            rd_row_q    <= next_row_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        on_cnt_q     <= on_cnt_q - ONW'(1);
                        frame_done_q <= (on_cnt_q == ONW'(1)) && last_plane_d && last_row_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    led_blank_q <= 1'b1;
                end
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_col     = rd_col_q;
    assign rd_row     = rd_row_q;
    assign led_addr   = led_addr_q;
    assign led_blank  = led_blank_q;
    assign led_latch  = led_latch_q;
    assign led_sclk   = led_sclk_q;
    assign led_rgb1   = led_rgb1_q;
    assign led_rgb2   = led_rgb2_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: a frame-offset reference model predicts every output cycle,
// expectations are queued by the driver and checked by an independent monitor.
module tb_hub75_bcm_scan;

    localparam int COLS        = 4;
    localparam int COLBITS     = 2;
    localparam int SCAN_ROWS   = 2;
    localparam int ROWBITS     = 1;
    localparam int BITDEPTH    = 2;
    localparam int BASE_ONTIME = 2;
    localparam int PXW         = 3 * BITDEPTH;
    localparam int SHIFT_LEN   = 2 * COLS + 2;
    localparam int FRAME_LEN   = SCAN_ROWS * (BITDEPTH * (2 * COLS + 4) + BASE_ONTIME * ((1 << BITDEPTH) - 1));
    localparam int ROW_LEN     = FRAME_LEN / SCAN_ROWS;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 rd_en;
    logic [COLBITS-1:0]   rd_col;
    logic [ROWBITS-1:0]   rd_row;
    logic [PXW-1:0]       rd_data1;
    logic [PXW-1:0]       rd_data2;
    logic [ROWBITS-1:0]   led_addr;
    logic                 led_blank;
    logic                 led_latch;
    logic                 led_sclk;
    logic [2:0]           led_rgb1;
    logic [2:0]           led_rgb2;
    logic                 frame_done;
    logic [2:0]           dbg_state;

    hub75_bcm_scan #(
        .COLS(COLS), .COLBITS(COLBITS), .SCAN_ROWS(SCAN_ROWS), .ROWBITS(ROWBITS),
        .BITDEPTH(BITDEPTH), .BASE_ONTIME(BASE_ONTIME)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .led_addr(led_addr), .led_blank(led_blank), .led_latch(led_latch), .led_sclk(led_sclk),
        .led_rgb1(led_rgb1), .led_rgb2(led_rgb2), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic               chk_rd;
        logic               chk_rgb;
        logic               rd_en;
        logic [COLBITS-1:0] rd_col;
        logic [ROWBITS-1:0] rd_row;
        logic [ROWBITS-1:0] led_addr;
        logic               blank;
        logic               latch;
        logic               sclk;
        logic [2:0]         rgb1;
        logic [2:0]         rgb2;
        logic               frame_done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [PXW-1:0] pix1 [SCAN_ROWS][COLS];
    logic [PXW-1:0] pix2 [SCAN_ROWS][COLS];

    // Reference model state: running flag, offset within the frame, held outputs.
    bit                 m_run = 1'b0;
    int                 m_off = 0;
    logic [ROWBITS-1:0] m_addr = '0;
    logic [2:0]         m_rgb1 = '0;
    logic [2:0]         m_rgb2 = '0;

    function automatic int plane_len(input int p);
        return 2 * COLS + 4 + (BASE_ONTIME << p);
    endfunction

    function automatic logic [2:0] bits_of(input logic [PXW-1:0] px, input int p);
        logic [PXW-1:0] s;
        s = px >> p;
        return {s[2*BITDEPTH], s[BITDEPTH], s[0]};
    endfunction

    // Pixel memory: answers a read strobe with data valid in the following cycle only.
    initial begin
        logic                pend;
        logic [COLBITS-1:0]  pcol;
        logic [ROWBITS-1:0]  prow;
        pend = 1'b0;
        pcol = '0;
        prow = '0;
        rd_data1 = '0;
        rd_data2 = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                rd_data1 = pix1[prow][pcol];
                rd_data2 = pix2[prow][pcol];
            end else begin
                rd_data1 = PXW'($urandom);
                rd_data2 = PXW'($urandom);
            end
            pend = rd_en;
            pcol = rd_col;
            prow = rd_row;
        end
    end

    task automatic predict_running(inout exp_t e);
        int o, row, r, p, col;
        o   = m_off;
        row = o / ROW_LEN;
        r   = o % ROW_LEN;
        p   = 0;
        while (r >= plane_len(p)) begin
            r = r - plane_len(p);
            p = p + 1;
        end
        if (r < SHIFT_LEN) begin
            if ((r % 2 == 0) && (r < 2 * COLS)) begin
                e.rd_en  = 1'b1;
                e.rd_col = COLBITS'(r / 2);
                e.rd_row = ROWBITS'(row);
                e.chk_rd = 1'b1;
            end
            if (r >= 2) begin
                col       = (r - 2) / 2;
                m_rgb1    = bits_of(pix1[row][col], p);
                m_rgb2    = bits_of(pix2[row][col], p);
                e.chk_rgb = 1'b1;
                e.sclk    = (r % 2 == 1);
            end
        end else if (r == SHIFT_LEN + 1) begin
            e.latch = 1'b1;
            m_addr  = ROWBITS'(row);
        end else if (r > SHIFT_LEN + 1) begin
            e.blank      = 1'b0;
            e.frame_done = (o == FRAME_LEN - 1);
        end
    endtask

    // Driver: applies inputs for the coming edge and queues the expected next cycle.
    task automatic step(input logic rst, input logic en);
        exp_t e;
        reset  = rst;
        enable = en;
        e       = '0;
        e.blank = 1'b1;
        if (rst) begin
            m_run    = 1'b0;
            m_addr   = '0;
            m_rgb1   = '0;
            m_rgb2   = '0;
            e.chk_rd = 1'b1;
            e.chk_rgb = 1'b1;
        end else begin
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1;
                    m_off = 0;
                end
            end else if (m_off == FRAME_LEN - 1) begin
                if (en) m_off = 0;
                else m_run = 1'b0;
            end else begin
                m_off = m_off + 1;
            end
            if (m_run) predict_running(e);
            else e.chk_rgb = 1'b1;
        end
        e.led_addr = m_addr;
        e.rgb1     = m_rgb1;
        e.rgb2     = m_rgb2;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic randomize_pixels();
        for (int r = 0; r < SCAN_ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pix1[r][c] = PXW'($urandom);
                pix2[r][c] = PXW'($urandom);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("led_blank", 32'(led_blank), 32'(e.blank));
                chk("led_latch", 32'(led_latch), 32'(e.latch));
                chk("led_sclk", 32'(led_sclk), 32'(e.sclk));
                chk("rd_en", 32'(rd_en), 32'(e.rd_en));
                chk("frame_done", 32'(frame_done), 32'(e.frame_done));
                chk("led_addr", 32'(led_addr), 32'(e.led_addr));
                if (e.chk_rd) begin
                    chk("rd_col", 32'(rd_col), 32'(e.rd_col));
                    chk("rd_row", 32'(rd_row), 32'(e.rd_row));
                end
                if (e.chk_rgb) begin
                    chk("led_rgb1", 32'(led_rgb1), 32'(e.rgb1));
                    chk("led_rgb2", 32'(led_rgb2), 32'(e.rgb2));
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        randomize_pixels();
        @(negedge clk);

        // Continuous enable over two full frames; column 0 of row 0 has a known colour.
        pix1[0][0] = 6'b10_01_00;
        repeat (3) step(1'b1, 1'b0);
        repeat (130) step(1'b0, 1'b1);
        repeat (70) step(1'b0, 1'b0);

        // Enable dropped early in the frame: frame still completes, then idles.
        randomize_pixels();
        repeat (2) step(1'b1, 1'b0);
        repeat (11) step(1'b0, 1'b1);
        repeat (70) step(1'b0, 1'b0);

        // Reset while shifting row 1, then a fresh start.
        randomize_pixels();
        repeat (2) step(1'b1, 1'b0);
        repeat (35) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b1);
        repeat (60) step(1'b0, 1'b0);

        // Random enable with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                randomize_pixels();
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 1'($urandom_range(0, 99) < 70));
            end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
